// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM states,
// default width and counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SUB_W_DEFAULT = 8;

  // Bit counter must hold 0..N-1 plus the increment on the last bit.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin.
// Ports: x, y, bin in; d, bout out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, diff = a - b - bin, LSB first.
// Ports: clk, rst_n, start/ready/busy/done, a, b, bin,
// diff, bout, ovf. ovf is built only with SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        st_q;
  state_t        st_d;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  diff_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic          d_bit;
  logic          br_nx;
  logic          accept;
  logic          last;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_nx)
  );

  assign ready  = (st_q != RUN);
  assign busy   = (st_q == RUN);
  assign done   = (st_q == DONE);
  assign accept = start & ready;
  assign last   = busy & (cnt_q == LAST);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (start) st_d = RUN;
      RUN:  if (last) st_d = DONE;
      DONE: st_d = start ? RUN : IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // diff shifts only while running, so it
  // holds the last result until the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (busy) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      br_q   <= br_nx;
      diff_q <= {d_bit, diff_q[N-1:1]};
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign diff = diff_q;
  assign bout = br_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last bit a_q[0]/b_q[0] are the operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (last) ovf_q <= (a_q[0] != b_q[0]) &&
                            (d_bit != a_q[0]);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=8),
// directed cases plus random operands vs. arithmetic model.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] exp_d;
  logic         exp_b;
  logic         exp_o;

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [N-1:0] ma,
                       input logic [N-1:0] mb,
                       input logic mbin);
    int full;
    full  = int'(ma) - int'(mb) - int'(mbin);
    exp_d = full[N-1:0];
    exp_b = (int'(ma) < int'(mb) + int'(mbin));
`ifdef SERIAL_SUB_OVF_EN
    exp_o = (ma[N-1] != mb[N-1]) && (exp_d[N-1] != ma[N-1]);
`else
    exp_o = 1'b0;
`endif
  endtask

  // Launch from a ready cycle and wait for done.
  // poke > 0 re-pulses start with junk operands mid-run.
  task automatic run_op(input logic [N-1:0] ta,
                        input logic [N-1:0] tb,
                        input logic tbin,
                        input int poke,
                        input string tag);
    int lat;
    bit seen;
    model(ta, tb, tbin);
    chk({tag, "_ready"}, ready, 1);
    a = ta;
    b = tb;
    bin = tbin;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    seen = 0;
    lat = 0;
    for (int k = 1; k <= N + 4; k++) begin
      if (k == poke) start = 1'b1;
      a = N'($urandom);
      b = N'($urandom);
      bin = 1'($urandom);
      tick();
      start = 1'b0;
      if (done) begin
        seen = 1;
        lat = k;
        break;
      end
    end
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_lat"}, lat, N);
    chk({tag, "_diff"}, diff, exp_d);
    chk({tag, "_bout"}, bout, exp_b);
    chk({tag, "_ovf"}, ovf, exp_o);
  endtask

  initial begin
    int gap;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic rbin;
    bit aborted;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    tick();
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    run_op(8'h5A, 8'h3C, 1'b0, -1, "basic");
    tick();
    chk("pulse_done", done, 0);
    chk("pulse_ready", ready, 1);

    run_op(8'h00, 8'h01, 1'b0, -1, "under");
    tick();
    run_op(8'h10, 8'h0F, 1'b1, -1, "binz");
    tick();
    run_op(8'h80, 8'h01, 1'b0, -1, "ovf1");
    tick();
    run_op(8'h7F, 8'hFF, 1'b0, -1, "ovf2");
    tick();

    run_op(8'h5A, 8'h3C, 1'b0, 3, "ign");
    tick();

    // Abort a run with asynchronous reset.
    a = 8'h5A;
    b = 8'h3C;
    bin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    chk("abort_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    aborted = 0;
    for (int k = 0; k < N + 3; k++) begin
      tick();
      if (done) aborted = 1;
    end
    chk("abort_nodone", aborted, 0);
    run_op(8'hC3, 8'h42, 1'b1, -1, "after_rst");
    tick();

    // Back-to-back: restart in the DONE cycle.
    run_op(8'h5A, 8'h3C, 1'b0, -1, "b2b1");
    chk("b2b_hold", diff, 8'h1E);
    chk("b2b_indone", done, 1);
    run_op(8'h03, 8'h05, 1'b0, -1, "b2b2");
    tick();

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin, -1, "rnd");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      if (gap > 0) chk("rnd_hold", diff, exp_d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
